fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard unit for the MIPS pipeline. It sits in EX.
- It tracks in-flight register writers in an internal age-ordered history shift register, one entry per downstream stage.
- For each EX source operand it produces a forward-select, taking the youngest matching writer.
- It raises a load-use stall while a matching load's data is not yet available, and keeps a saturating stall-cycle counter.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands checked (rs, rt, ...).
- DEPTH, 2, number of tracked downstream stages; entry 0 = EX/MEM, entry 1 = MEM/WB, and so on. Legal range is 1 to 6.
- LOAD_LAT, 1, number of entries, counted from 0, in which a load's result is not forwardable. Must be less than DEPTH.
- LEGACY_ENC, 1, select encoding. 1 gives 2 for EX/MEM and 1 for MEM/WB; it is only legal with DEPTH=2. 0 gives k+1 for entry k.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous and active-low.
- ex_valid  in  1  a real instruction is in EX.
- ex_rd  in  REG_AW  destination register of the EX instruction.
- ex_we  in  1  the EX instruction writes the register file.
- ex_is_load  in  1  the EX instruction is a load.
- ex_src  in  NUM_SRC*REG_AW  packed source register numbers; operand i is at [i*REG_AW +: REG_AW].
- flush  in  1  kill the EX instruction (branch or exception).
- fwd_sel  out  NUM_SRC*SEL_W  packed forward selects, where SEL_W = $clog2(DEPTH+1). Value 0 selects the register file.
- stall  out  1  hold PC, IF/ID and ID/EX; bubble into EX/MEM.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- History entry: {v, we, ld, rd}. An entry is a hit for operand i when v && we && rd!=0 && rd==src_i.
- Shift: on every clk edge, hist[k+1] <= hist[k].
  - hist[0] <= {1, ex_we, ex_is_load, ex_rd} when ex_valid && !stall && !flush.
  - Otherwise hist[0] <= bubble (all zero).
  - The oldest entry is discarded.
- Forwarding (combinational, same cycle):
  - For operand i, k = lowest index with a hit; youngest wins.
  - fwd_sel_i = k+1 when LEGACY_ENC=0. With LEGACY_ENC=1, k=0 gives 2 and k=1 gives 1.
  - No hit gives 0.
  - src_i==0 always gives 0.
- Load-use stall (combinational):
  - stall = ex_valid && !flush && (some operand i has its youngest hit at k < LOAD_LAT and that entry has ld=1).
  - An older non-load hit on the same register never masks a younger load hit.
  - While stalled, bubbles enter hist[0] and the load entry advances one entry per cycle. The stall drops automatically once the load reaches entry LOAD_LAT. Stall duration = LOAD_LAT - k cycles.
  - While stall=1, fwd_sel is don't-care to the datapath but must still follow the rules above.
- flush has priority over stall: stall=0 in the flush cycle and a bubble is pushed.
- stall_cnt increments on each clk edge where stall=1. It saturates at all-ones and never wraps.
- Reset (asynchronous, reset=0):
  - All hist entries become 0 and stall_cnt becomes 0.
  - fwd_sel is 0 and stall is 0 as soon as reset is asserted.
  - Reset mid-stall abandons the stall; the first cycle after reset release sees an empty history.
- No handshake other than stall. Latency is 0 cycles for forwarding and stall; history updates one cycle after issue.
- Illegal parameter combinations (LEGACY_ENC=1 with DEPTH!=2, or LOAD_LAT>=DEPTH) trigger an elaboration-time $error.

Decomposition:
- Shared package mips_pkg holds:
  - the hist_entry_t struct {v, we, ld, rd};
  - constants FWD_RF=0, FWD_EXMEM_LEGACY=2, FWD_MEMWB_LEGACY=1;
  - the function fwd_sel_w(depth).
- One sub-module, fwd_match, per operand: a priority encoder from the hist vector and one source register to the hit index, hit flag and load flag. Instantiate it NUM_SRC times with generate.
- The history shift register, stall logic and counter stay in the top module.

Test Plan:
- Defaults; issue add to $8 (we=1), then next cycle EX src0=$8 -> fwd_sel[0]=2. One cycle later with the same src -> fwd_sel[0]=1. One more cycle -> fwd_sel[0]=0.
- Issue lw $9, then next cycle src1=$9 -> stall=1 for exactly 1 cycle. Following cycle fwd_sel[1]=1 and stall=0. stall_cnt=1.
- Writes to $5 two cycles apart (older non-load, younger load), then consumer src0=$5 -> younger wins: stall=1, then fwd_sel[0]=1 (LEGACY_ENC=1).
- Destination $0 with we=1, consumer src0=$0 -> fwd_sel=0 and no stall. flush asserted in the load cycle, then consumer of that load register -> no stall, no forwarding.
- Parameters DEPTH=4, LOAD_LAT=2, LEGACY_ENC=0, NUM_SRC=3. Issue lw $3, then src2=$3 -> stall 2 cycles, then fwd_sel[2]=3. Force 2^CNT_W+5 stall cycles -> stall_cnt saturates at 16'hFFFF.
- reset asserted low during a stall -> stall=0 and stall_cnt=0 immediately. After release, a consumer of the prior load register -> fwd_sel=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline types and constants for the MIPS forwarding/hazard logic.
package mips_pkg;

    // Widest register address the history entries can hold.
    localparam int HIST_RD_W = 8;

    localparam int FWD_RF           = 0;
    localparam int FWD_EXMEM_LEGACY = 2;
    localparam int FWD_MEMWB_LEGACY = 1;

    typedef struct packed {
        logic                 v;
        logic                 we;
        logic                 ld;
        logic [HIST_RD_W-1:0] rd;
    } hist_entry_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority encoder: finds the youngest history entry writing one source register.
module fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int IDX_W = fwd_sel_w(DEPTH)
) (
    input  hist_entry_t [DEPTH-1:0] i_hist,
    input  logic [HIST_RD_W-1:0]    i_src,
    output logic                    o_hit,
    output logic [IDX_W-1:0]        o_idx,
    output logic                    o_ld
);

    // Scan oldest to youngest so the lowest matching index is the one that sticks.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        o_ld  = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_hist[k].v && i_hist[k].we && (i_hist[k].rd != '0) &&
                (i_hist[k].rd == i_src)) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(k);
                o_ld  = i_hist[k].ld;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select and load-use stall generation over an age-ordered
// history of in-flight register writers, plus a saturating stall-cycle counter.
module fwd_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_LAT   = 1,
    parameter int LEGACY_ENC = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = fwd_sel_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ex_valid,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_we,
    input  logic                      ex_is_load,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    if (DEPTH < 1 || DEPTH > 6) begin : g_bad_depth
        $error("fwd_hazard_unit: DEPTH must be in 1..6");
    end
    if (LOAD_LAT >= DEPTH) begin : g_bad_lat
        $error("fwd_hazard_unit: LOAD_LAT must be less than DEPTH");
    end
    if (LEGACY_ENC != 0 && DEPTH != 2) begin : g_bad_enc
        $error("fwd_hazard_unit: LEGACY_ENC=1 requires DEPTH=2");
    end
    if (REG_AW > HIST_RD_W) begin : g_bad_aw
        $error("fwd_hazard_unit: REG_AW exceeds history rd width");
    end

    hist_entry_t [DEPTH-1:0] r_hist;
    logic [CNT_W-1:0]        r_stall_cnt;
    hist_entry_t             w_new;
    logic                    w_push;
    logic [NUM_SRC-1:0]      w_ld_use;

    // stall is the only flow control: while high, upstream holds PC, IF/ID and
    // ID/EX, and the EX instruction is not recorded (a bubble enters EX/MEM).
    // flush wins over stall and also pushes a bubble.
    assign stall  = ex_valid && !flush && (|w_ld_use);
    assign w_push = ex_valid && !stall && !flush;

    always_comb begin
        w_new = '0;
        if (w_push) begin
            w_new.v  = 1'b1;
            w_new.we = ex_we;
            w_new.ld = ex_is_load;
            w_new.rd = HIST_RD_W'(ex_rd);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist <= '0;
        end else begin
            r_hist[0] <= w_new;
            for (int k = 1; k < DEPTH; k++) begin
                r_hist[k] <= r_hist[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic             w_hit;
        logic             w_ld;
        logic [SEL_W-1:0] w_idx;
        logic [SEL_W-1:0] w_sel;

        fwd_match #(
            .DEPTH (DEPTH)
        ) u_match (
            .i_hist (r_hist),
            .i_src  (HIST_RD_W'(ex_src[i*REG_AW +: REG_AW])),
            .o_hit  (w_hit),
            .o_idx  (w_idx),
            .o_ld   (w_ld)
        );

        always_comb begin
            w_sel = SEL_W'(FWD_RF);
            if (w_hit) begin
                if (LEGACY_ENC != 0) begin
                    w_sel = (w_idx == '0) ? SEL_W'(FWD_EXMEM_LEGACY) : SEL_W'(FWD_MEMWB_LEGACY);
                end else begin
                    w_sel = w_idx + SEL_W'(1);
                end
            end
        end

        // A load is still unavailable while it sits below entry LOAD_LAT.
        assign w_ld_use[i] = w_hit && w_ld && (int'(w_idx) < LOAD_LAT);
        assign fwd_sel[i*SEL_W +: SEL_W] = w_sel;
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, multi-cycle
// sequences, randomized traffic against a timestamp-based writer model.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_s_n;

    logic        a_valid, a_we, a_ld, a_flush, a_stall;
    logic [4:0]  a_rd;
    logic [9:0]  a_src;
    logic [3:0]  a_sel;
    logic [15:0] a_cnt;

    logic        b_valid, b_we, b_ld, b_flush, b_stall;
    logic [4:0]  b_rd;
    logic [14:0] b_src;
    logic [8:0]  b_sel;
    logic [15:0] b_cnt;

    logic        s_valid, s_we, s_ld, s_flush, s_stall;
    logic [4:0]  s_rd;
    logic [4:0]  s_src;
    logic [2:0]  s_sel;
    logic [15:0] s_cnt;

    fwd_hazard_unit u_a (
        .clk(clk), .reset(rst_n), .ex_valid(a_valid), .ex_rd(a_rd), .ex_we(a_we),
        .ex_is_load(a_ld), .ex_src(a_src), .flush(a_flush), .fwd_sel(a_sel),
        .stall(a_stall), .stall_cnt(a_cnt)
    );

    fwd_hazard_unit #(.NUM_SRC(3), .DEPTH(4), .LOAD_LAT(2), .LEGACY_ENC(0)) u_b (
        .clk(clk), .reset(rst_n), .ex_valid(b_valid), .ex_rd(b_rd), .ex_we(b_we),
        .ex_is_load(b_ld), .ex_src(b_src), .flush(b_flush), .fwd_sel(b_sel),
        .stall(b_stall), .stall_cnt(b_cnt)
    );

    fwd_hazard_unit #(.NUM_SRC(1), .DEPTH(6), .LOAD_LAT(5), .LEGACY_ENC(0)) u_s (
        .clk(clk), .reset(rst_s_n), .ex_valid(s_valid), .ex_rd(s_rd), .ex_we(s_we),
        .ex_is_load(s_ld), .ex_src(s_src), .flush(s_flush), .fwd_sel(s_sel),
        .stall(s_stall), .stall_cnt(s_cnt)
    );

    // Reference model: each recorded writer carries the cycle it sat in EX;
    // its history position at cycle t is t - cyc - 1.
    typedef struct {
        int rd;
        bit we;
        bit ld;
        int cyc;
    } wr_t;

    wr_t qa[$], qb[$], qs[$];
    int  now = 0, now_s = 0;
    int  cnt_a = 0, cnt_b = 0, cnt_s = 0, raw_s = 0;
    int  n_cmp = 0, n_mis = 0;

    function automatic void m_eval(input wr_t q[$], input int nw, input int depth, input int lat,
                                   input bit legacy, input int src, output int sel, output bit lu);
        sel = 0;
        lu  = 1'b0;
        for (int j = q.size() - 1; j >= 0; j--) begin
            int k;
            k = nw - q[j].cyc - 1;
            if (k < depth && q[j].we && q[j].rd != 0 && q[j].rd == src) begin
                sel = legacy ? ((k == 0) ? 2 : 1) : k + 1;
                lu  = q[j].ld && (k < lat);
                return;
            end
        end
    endfunction

    function automatic bit m_stall(input wr_t q[$], input int nw, input int depth, input int lat,
                                   input bit legacy, input int nsrc, input logic [14:0] srcs,
                                   input bit valid, input bit flush);
        int sel;
        bit lu;
        if (!valid || flush) return 1'b0;
        for (int i = 0; i < nsrc; i++) begin
            m_eval(q, nw, depth, lat, legacy, int'(srcs[i*5 +: 5]), sel, lu);
            if (lu) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input wr_t q[$], input int nw, input int depth,
                              input int lat, input bit legacy, input int nsrc, input int selw,
                              input logic [14:0] srcs, input logic [8:0] sels, input bit valid,
                              input bit flush, input logic stall_act, input int cnt_act,
                              input int cnt_exp);
        int sel;
        bit lu;
        for (int i = 0; i < nsrc; i++) begin
            m_eval(q, nw, depth, lat, legacy, int'(srcs[i*5 +: 5]), sel, lu);
            chk($sformatf("%s sel%0d", tag, i),
                int'((sels >> (i*selw)) & ((9'd1 << selw) - 9'd1)), sel);
        end
        chk({tag, " stall"}, int'(stall_act),
            int'(m_stall(q, nw, depth, lat, legacy, nsrc, srcs, valid, flush)));
        chk({tag, " cnt"}, cnt_act, cnt_exp);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            if (m_stall(qa, now, 2, 1, 1'b1, 2, 15'(a_src), a_valid, a_flush)) begin
                if (cnt_a < 65535) cnt_a++;
            end else if (a_valid && !a_flush) begin
                qa.push_back('{int'(a_rd), a_we, a_ld, now});
            end
            if (m_stall(qb, now, 4, 2, 1'b0, 3, b_src, b_valid, b_flush)) begin
                if (cnt_b < 65535) cnt_b++;
            end else if (b_valid && !b_flush) begin
                qb.push_back('{int'(b_rd), b_we, b_ld, now});
            end
            while (qa.size() > 8) void'(qa.pop_front());
            while (qb.size() > 8) void'(qb.pop_front());
            now++;
        end
    end

    always @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            qs.delete();
            cnt_s = 0;
            raw_s = 0;
        end else begin
            if (m_stall(qs, now_s, 6, 5, 1'b0, 1, 15'(s_src), s_valid, s_flush)) begin
                raw_s++;
                if (cnt_s < 65535) cnt_s++;
            end else if (s_valid && !s_flush) begin
                qs.push_back('{int'(s_rd), s_we, s_ld, now_s});
            end
            while (qs.size() > 8) void'(qs.pop_front());
            now_s++;
        end
    end

    task automatic set_a(input bit v, input int rd, input bit we, input bit ld,
                         input int s0, input int s1, input bit fl);
        a_valid = v;
        a_rd    = 5'(rd);
        a_we    = we;
        a_ld    = ld;
        a_src   = {5'(s1), 5'(s0)};
        a_flush = fl;
    endtask

    task automatic set_b(input bit v, input int rd, input bit we, input bit ld,
                         input int s0, input int s1, input int s2, input bit fl);
        b_valid = v;
        b_rd    = 5'(rd);
        b_we    = we;
        b_ld    = ld;
        b_src   = {5'(s2), 5'(s1), 5'(s0)};
        b_flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit v; int rd; bit we; bit ld; int s0; int s1; bit fl;
        int e0; int e1; bit est; int ecnt;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input bit v, input int rd, input bit we, input bit ld,
                                input int s0, input int s1, input bit fl,
                                input int e0, input int e1, input bit est, input int ecnt);
        vec_t r;
        r = '{v, rd, we, ld, s0, s1, fl, e0, e1, est, ecnt};
        return r;
    endfunction

    task automatic run_main();
        // Defaults instance: one record per cycle, history evolving row to row.
        tbl[0]  = mk(1,  8, 1, 0,  0,  0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(1,  0, 0, 0,  8,  0, 0,  2, 0, 0, 0);
        tbl[2]  = mk(1,  0, 0, 0,  8,  0, 0,  1, 0, 0, 0);
        tbl[3]  = mk(1,  0, 0, 0,  8,  0, 0,  0, 0, 0, 0);
        tbl[4]  = mk(1,  9, 1, 1,  0,  0, 0,  0, 0, 0, 0);
        tbl[5]  = mk(1,  0, 0, 0,  0,  9, 0,  0, 2, 1, 0);
        tbl[6]  = mk(1,  0, 0, 0,  0,  9, 0,  0, 1, 0, 1);
        tbl[7]  = mk(1,  5, 1, 0,  0,  0, 0,  0, 0, 0, 1);
        tbl[8]  = mk(1,  5, 1, 1,  0,  0, 0,  0, 0, 0, 1);
        tbl[9]  = mk(1,  0, 0, 0,  5,  0, 0,  2, 0, 1, 1);
        tbl[10] = mk(1,  0, 0, 0,  5,  0, 0,  1, 0, 0, 2);
        tbl[11] = mk(1,  0, 1, 1,  0,  0, 0,  0, 0, 0, 2);
        tbl[12] = mk(1,  0, 0, 0,  0,  0, 0,  0, 0, 0, 2);
        tbl[13] = mk(1,  7, 1, 1,  0,  0, 1,  0, 0, 0, 2);
        tbl[14] = mk(1,  0, 0, 0,  7,  7, 0,  0, 0, 0, 2);
        tbl[15] = mk(1,  6, 1, 1,  0,  0, 0,  0, 0, 0, 2);
        tbl[16] = mk(1,  0, 0, 0,  6,  0, 1,  2, 0, 0, 2);
        tbl[17] = mk(1,  0, 0, 0,  6,  0, 0,  1, 0, 0, 2);
        tbl[18] = mk(1,  4, 1, 1,  0,  0, 0,  0, 0, 0, 2);
        tbl[19] = mk(0,  0, 0, 0,  4,  0, 0,  2, 0, 0, 2);
        tbl[20] = mk(1,  0, 0, 0,  4,  0, 0,  1, 0, 0, 2);
        tbl[21] = mk(1, 10, 1, 0,  0,  0, 0,  0, 0, 0, 2);
        tbl[22] = mk(1, 11, 1, 0, 10, 10, 0,  2, 2, 0, 2);
        tbl[23] = mk(1,  0, 0, 0, 11, 10, 0,  2, 1, 0, 2);

        for (int r = 0; r < 24; r++) begin
            set_a(tbl[r].v, tbl[r].rd, tbl[r].we, tbl[r].ld, tbl[r].s0, tbl[r].s1, tbl[r].fl);
            @(negedge clk);
            chk($sformatf("tbl%0d sel0", r),  int'(a_sel[1:0]), tbl[r].e0);
            chk($sformatf("tbl%0d sel1", r),  int'(a_sel[3:2]), tbl[r].e1);
            chk($sformatf("tbl%0d stall", r), int'(a_stall),    int'(tbl[r].est));
            chk($sformatf("tbl%0d cnt", r),   int'(a_cnt),      tbl[r].ecnt);
            next_cycle();
        end
        set_a(0, 0, 0, 0, 0, 0, 0);

        // Wide instance: lw $3 then a consumer on operand 2 stalls two cycles.
        set_b(1, 3, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("b lw stall", int'(b_stall), 0);
        next_cycle();
        set_b(1, 0, 0, 0, 0, 0, 3, 0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk($sformatf("b use%0d stall", t), int'(b_stall), (t < 2) ? 1 : 0);
            chk($sformatf("b use%0d sel2", t), int'(b_sel[8:6]), t + 1);
            next_cycle();
        end
        @(negedge clk);
        chk("b cnt after use", int'(b_cnt), 2);
        next_cycle();

        // Randomized traffic on both instances, scored by the model.
        for (int c = 0; c < 1500; c++) begin
            a_valid = ($urandom_range(0, 9) != 0);
            a_rd    = 5'($urandom_range(0, 7));
            a_we    = ($urandom_range(0, 3) != 0);
            a_ld    = ($urandom_range(0, 2) == 0);
            a_src   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            a_flush = ($urandom_range(0, 9) == 0);
            b_valid = ($urandom_range(0, 9) != 0);
            b_rd    = 5'($urandom_range(0, 7));
            b_we    = ($urandom_range(0, 3) != 0);
            b_ld    = ($urandom_range(0, 2) == 0);
            b_src   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            b_flush = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            check_inst("rnd a", qa, now, 2, 1, 1'b1, 2, 2, 15'(a_src), 9'(a_sel),
                       a_valid, a_flush, a_stall, int'(a_cnt), cnt_a);
            check_inst("rnd b", qb, now, 4, 2, 1'b0, 3, 3, b_src, b_sel,
                       b_valid, b_flush, b_stall, int'(b_cnt), cnt_b);
            next_cycle();
        end

        // Reset in the middle of a load-use stall.
        set_a(0, 0, 0, 0, 0, 0, 0);
        set_b(1, 3, 1, 1, 0, 0, 0, 0);
        next_cycle();
        set_b(1, 0, 0, 0, 0, 0, 3, 0);
        @(negedge clk);
        chk("pre-rst stall", int'(b_stall), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst stall", int'(b_stall), 0);
        chk("rst cnt b", int'(b_cnt), 0);
        chk("rst cnt a", int'(a_cnt), 0);
        chk("rst sel b", int'(b_sel), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst sel2", int'(b_sel[8:6]), 0);
        chk("post-rst stall", int'(b_stall), 0);
        chk("post-rst cnt", int'(b_cnt), 0);
        next_cycle();
    endtask

    task automatic run_sat();
        // Back-to-back load-to-self consumers: 5 of every 6 cycles stall.
        for (int c = 0; c < 90000 && raw_s < 65541; c++) begin
            @(negedge clk);
            if (c < 40) begin
                check_inst("sat", qs, now_s, 6, 5, 1'b0, 1, 3, 15'(s_src), 9'(s_sel),
                           s_valid, s_flush, s_stall, int'(s_cnt), cnt_s);
            end else if (raw_s == 65534 || raw_s == 65535) begin
                chk("sat edge cnt", int'(s_cnt), cnt_s);
            end
        end
        if (raw_s < 65541) chk("sat timeout stalls", raw_s, 65541);
        @(negedge clk);
        chk("sat cnt", int'(s_cnt), 65535);
        repeat (12) @(negedge clk);
        chk("sat hold", int'(s_cnt), 65535);
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        set_a(0, 0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0, 0, 0);
        s_valid = 1'b1;
        s_rd    = 5'd3;
        s_we    = 1'b1;
        s_ld    = 1'b1;
        s_src   = 5'd3;
        s_flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset a sel",   int'(a_sel),   0);
        chk("reset a stall", int'(a_stall), 0);
        chk("reset a cnt",   int'(a_cnt),   0);
        chk("reset b sel",   int'(b_sel),   0);
        chk("reset b stall", int'(b_stall), 0);
        chk("reset s cnt",   int'(s_cnt),   0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        fork
            run_main();
            run_sat();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
